// File: rtl/hist_pkg.sv
// Shared definitions for the histogram engine: FSM state encoding, default
// geometry and a clog2 helper usable in constant expressions.
package hist_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ACCUM   = 3'd2,
    S_DRAIN   = 3'd3,
    S_READOUT = 3'd4,
    S_DONE    = 3'd5
  } hist_state_e;

  localparam int DEF_PIXEL_W      = 8;
  localparam int DEF_COUNT_W      = 32;
  localparam int DEF_FRAME_PIXELS = 76800;

  function automatic int hist_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/hist_bin_ram.sv
// Bin storage: simple dual-port RAM, one write port and one registered read
// port; a read of the address being written returns the old contents.
module hist_bin_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/histogram_engine.sv
// Streaming histogram engine: clear bins, accumulate one frame, stream bins out.
// Define HIST_CDF_EN to emit the saturating cumulative sum instead of raw counts.
module histogram_engine import hist_pkg::*; #(
  parameter int PIXEL_W      = DEF_PIXEL_W,
  parameter int BIN_SHIFT    = 0,
  parameter int COUNT_W      = DEF_COUNT_W,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic                           pix_valid_i,
  input  logic [PIXEL_W-1:0]             pix_i,
  output logic                           pix_ready_o,
  output logic                           rd_valid_o,
  input  logic                           rd_ready_i,
  output logic [PIXEL_W-BIN_SHIFT-1:0]   rd_idx_o,
  output logic [COUNT_W-1:0]             rd_count_o,
  output logic                           rd_last_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           sat_o
);

  localparam int IDX_W  = PIXEL_W - BIN_SHIFT;
  localparam int NBINS  = 1 << IDX_W;
  localparam int PCNT_W = hist_clog2(FRAME_PIXELS + 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

`ifdef HIST_CDF_EN
  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                 input logic [COUNT_W-1:0] b);
    logic [COUNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COUNT_W] ? CNT_MAX : s[COUNT_W-1:0];
  endfunction
`endif

  hist_state_e        state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q;
  logic [PCNT_W-1:0]  pix_cnt_q;
  logic               drain_q;
  logic               accept, start_ok;
  logic [IDX_W-1:0]   pix_bin;
  logic               vld_p1_q, vld_p2_q;
  logic [IDX_W-1:0]   bin_p1_q, bin_p2_q;
  logic [COUNT_W-1:0] cnt_p2_q, old_cnt, new_cnt;
  logic               sat_hit;
  logic               ram_we, ram_re;
  logic [IDX_W-1:0]   ram_waddr, ram_raddr;
  logic [COUNT_W-1:0] ram_wdata, ram_rdata;
  logic [IDX_W:0]     fetch_ptr_q;
  logic [IDX_W-1:0]   fidx_q;
  logic               fpend_q, load_out, fetch_en, rd_hs;
  logic [COUNT_W-1:0] out_count;
  logic               rd_valid_q, rd_last_q, done_q, sat_q;
  logic [IDX_W-1:0]   rd_idx_q;
  logic [COUNT_W-1:0] rd_count_q;

  assign accept   = pix_valid_i && (state_q == S_ACCUM);
  assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign pix_bin  = IDX_W'(pix_i >> BIN_SHIFT);
  assign rd_hs    = rd_valid_q && rd_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_CLEAR;
      S_CLEAR:        if (&clr_idx_q) state_d = S_ACCUM;
      S_ACCUM:        if (accept && (pix_cnt_q == PCNT_W'(FRAME_PIXELS - 1))) state_d = S_DRAIN;
      S_DRAIN:        if (drain_q) state_d = S_READOUT;
      S_READOUT:      if (rd_hs && rd_last_q) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clr_idx_q <= '0;
      pix_cnt_q <= '0;
      drain_q   <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      clr_idx_q <= (state_q == S_CLEAR) ? clr_idx_q + 1'b1 : '0;
      if (state_q != S_ACCUM) pix_cnt_q <= '0;
      else if (accept)        pix_cnt_q <= pix_cnt_q + 1'b1;
      drain_q   <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
      vld_p1_q  <= accept;
      vld_p2_q  <= vld_p1_q;
      if (start_ok)     sat_q <= 1'b0;
      else if (sat_hit) sat_q <= 1'b1;
    end
  end

  // S1 -> S2: bin registered alongside the RAM read issued this cycle
  always_ff @(posedge clk_i) begin
    if (accept) bin_p1_q <= pix_bin;
    if (vld_p1_q) begin
      bin_p2_q <= bin_p1_q;
      cnt_p2_q <= new_cnt;
    end
  end

  // S2: the RAM still holds the pre-write value of last cycle's bin, so forward it
  assign old_cnt = (vld_p2_q && (bin_p2_q == bin_p1_q)) ? cnt_p2_q : ram_rdata;
  assign new_cnt = sat_inc(old_cnt);
  assign sat_hit = vld_p1_q && (old_cnt == CNT_MAX);

  assign ram_we    = (state_q == S_CLEAR) || vld_p1_q;
  assign ram_waddr = (state_q == S_CLEAR) ? clr_idx_q : bin_p1_q;
  assign ram_wdata = (state_q == S_CLEAR) ? '0 : new_cnt;
  assign ram_re    = accept || fetch_en;
  assign ram_raddr = (state_q == S_READOUT) ? fetch_ptr_q[IDX_W-1:0] : pix_bin;

  hist_bin_ram #(
    .DEPTH (NBINS),
    .AW    (IDX_W),
    .DW    (COUNT_W)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Readout: fetch runs one bin ahead of the output register; both stall together
  assign load_out = fpend_q && (!rd_valid_q || rd_ready_i);
  assign fetch_en = (state_q == S_READOUT) && !fetch_ptr_q[IDX_W] && (!fpend_q || load_out);

`ifdef HIST_CDF_EN
  logic [COUNT_W-1:0] acc_q;
  assign out_count = sat_add(acc_q, ram_rdata);
  always_ff @(posedge clk_i) begin
    if (state_q != S_READOUT) acc_q <= '0;
    else if (load_out)        acc_q <= out_count;
  end
`else
  assign out_count = ram_rdata;
`endif

  always_ff @(posedge clk_i) begin
    if (fetch_en) fidx_q <= fetch_ptr_q[IDX_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_ptr_q <= '0;
      fpend_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
      rd_count_q  <= '0;
      rd_last_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (state_q != S_READOUT) begin
        fetch_ptr_q <= '0;
        fpend_q     <= 1'b0;
      end else if (fetch_en) begin
        fetch_ptr_q <= fetch_ptr_q + 1'b1;
        fpend_q     <= 1'b1;
      end else if (load_out) begin
        fpend_q     <= 1'b0;
      end
      if (load_out) begin
        rd_valid_q <= 1'b1;
        rd_idx_q   <= fidx_q;
        rd_count_q <= out_count;
        rd_last_q  <= &fidx_q;
      end else if (rd_hs) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
      done_q <= (state_q == S_READOUT) && rd_hs && rd_last_q;
    end
  end

  assign pix_ready_o = (state_q == S_ACCUM);
  assign busy_o      = (state_q == S_CLEAR) || (state_q == S_ACCUM) ||
                       (state_q == S_DRAIN) || (state_q == S_READOUT);
  assign rd_valid_o  = rd_valid_q;
  assign rd_idx_o    = rd_idx_q;
  assign rd_count_o  = rd_count_q;
  assign rd_last_o   = rd_last_q;
  assign done_o      = done_q;
  assign sat_o       = sat_q;

endmodule

// File: tb/tb_histogram_engine.sv
// Directed bench for histogram_engine: instance A uses the default 256-bin
// geometry, B uses BIN_SHIFT=4, C uses a 4-bit saturating counter.
`timescale 1ns/1ps
module tb_histogram_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start_a, start_b, start_c;
  logic pv, rdy;
  logic [7:0] pix;

  logic pr_a, rv_a, last_a, busy_a, done_a, sat_a;
  logic [7:0] idx_a;
  logic [31:0] cnt_a;
  logic pr_b, rv_b, last_b, busy_b, done_b, sat_b;
  logic [3:0] idx_b;
  logic [31:0] cnt_b;
  logic pr_c, rv_c, last_c, busy_c, done_c, sat_c;
  logic [7:0] idx_c;
  logic [3:0] cnt_c;

  histogram_engine #(.PIXEL_W(8), .BIN_SHIFT(0), .COUNT_W(32), .FRAME_PIXELS(16)) u_a (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .pix_valid_i(pv), .pix_i(pix),
    .pix_ready_o(pr_a), .rd_valid_o(rv_a), .rd_ready_i(rdy), .rd_idx_o(idx_a),
    .rd_count_o(cnt_a), .rd_last_o(last_a), .busy_o(busy_a), .done_o(done_a), .sat_o(sat_a));

  histogram_engine #(.PIXEL_W(8), .BIN_SHIFT(4), .COUNT_W(32), .FRAME_PIXELS(4)) u_b (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_b), .pix_valid_i(pv), .pix_i(pix),
    .pix_ready_o(pr_b), .rd_valid_o(rv_b), .rd_ready_i(rdy), .rd_idx_o(idx_b),
    .rd_count_o(cnt_b), .rd_last_o(last_b), .busy_o(busy_b), .done_o(done_b), .sat_o(sat_b));

  histogram_engine #(.PIXEL_W(8), .BIN_SHIFT(0), .COUNT_W(4), .FRAME_PIXELS(20)) u_c (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_c), .pix_valid_i(pv), .pix_i(pix),
    .pix_ready_o(pr_c), .rd_valid_o(rv_c), .rd_ready_i(rdy), .rd_idx_o(idx_c),
    .rd_count_o(cnt_c), .rd_last_o(last_c), .busy_o(busy_c), .done_o(done_c), .sat_o(sat_c));

  int sel;
  logic pr_m, rv_m, last_m, done_m;
  logic [7:0] idx_m;
  logic [31:0] cnt_m;

  always_comb begin
    pr_m = pr_a; rv_m = rv_a; last_m = last_a; done_m = done_a; idx_m = idx_a; cnt_m = cnt_a;
    if (sel == 1) begin
      pr_m = pr_b; rv_m = rv_b; last_m = last_b; done_m = done_b;
      idx_m = {4'b0, idx_b}; cnt_m = cnt_b;
    end else if (sel == 2) begin
      pr_m = pr_c; rv_m = rv_c; last_m = last_c; done_m = done_c;
      idx_m = idx_c; cnt_m = {28'b0, cnt_c};
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] cap [256];
  logic [31:0] exp_bin [256];
  logic [7:0]  px [32];
  int hs, order_err, stall_viol, last_cnt, last_idx, done_cnt;
  bit prev_stall, timeout;
  logic [7:0] p_idx;
  logic [31:0] p_cnt;
  logic p_last;

  // Capture every read handshake and watch that stalled words stay put
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall && (!rv_m || idx_m !== p_idx || cnt_m !== p_cnt || last_m !== p_last))
        stall_viol++;
      prev_stall = rv_m && !rdy;
      p_idx = idx_m; p_cnt = cnt_m; p_last = last_m;
      if (rv_m && rdy) begin
        if (int'(idx_m) != hs) order_err++;
        cap[idx_m] = cnt_m;
        if (last_m) begin last_cnt++; last_idx = int'(idx_m); end
        hs++;
      end
      if (done_m) done_cnt++;
    end
  end

  task automatic set_start(input int s, input logic v);
    start_a = (s == 0) ? v : 1'b0;
    start_b = (s == 1) ? v : 1'b0;
    start_c = (s == 2) ? v : 1'b0;
  endtask

`ifdef HIST_CDF_EN
  task automatic to_cdf(input int nb, input longint maxv);
    longint acc;
    acc = 0;
    for (int k = 0; k < nb; k++) begin
      acc = acc + longint'(exp_bin[k]);
      if (acc > maxv) acc = maxv;
      exp_bin[k] = acc[31:0];
    end
  endtask
`endif

  task automatic run_frame(input int s, input int n, input bit rnd, input bit poke);
    int i, guard;
    bit acc;
    sel = s;
    for (int k = 0; k < 256; k++) cap[k] = 32'hDEAD_BEEF;
    hs = 0; order_err = 0; stall_viol = 0; last_cnt = 0; last_idx = -1; done_cnt = 0;
    prev_stall = 0; timeout = 0; rdy = 1'b1;
    @(posedge clk); #1;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    guard = 0;
    while (!pr_m && guard < 1000) begin
      pv = 1'b1; pix = 8'hAA;
      @(posedge clk); #1; guard++;
    end
    i = 0;
    while (i < n && guard < 2000) begin
      pv = 1'b1; pix = px[i]; acc = pr_m;
      set_start(s, poke && (i == 5));
      @(posedge clk); #1; guard++;
      if (acc) i++;
    end
    set_start(s, 1'b0); pv = 1'b0; pix = 8'h00;
    while (!done_m && guard < 6000) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1; guard++;
    end
    timeout = !done_m;
    rdy = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; pv = 1'b0; pix = 8'h00; rdy = 1'b1; sel = 0;
    set_start(0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({pr_a, rv_a, last_a, busy_a, done_a, sat_a, idx_a, cnt_a} !== '0) begin
      errors++; $display("FAIL reset_a: got %h, want 0", {pr_a, rv_a, last_a, busy_a, done_a, sat_a, idx_a, cnt_a});
    end
    checks++;
    if ({pr_b, rv_b, last_b, busy_b, done_b, sat_b, idx_b, cnt_b} !== '0) begin
      errors++; $display("FAIL reset_b: got %h, want 0", {pr_b, rv_b, last_b, busy_b, done_b, sat_b, idx_b, cnt_b});
    end
    checks++;
    if ({pr_c, rv_c, last_c, busy_c, done_c, sat_c, idx_c, cnt_c} !== '0) begin
      errors++; $display("FAIL reset_c: got %h, want 0", {pr_c, rv_c, last_c, busy_c, done_c, sat_c, idx_c, cnt_c});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    for (int k = 0; k < 16; k++) px[k] = k[7:0];
    run_frame(0, 16, 1'b0, 1'b1);
    for (int k = 0; k < 256; k++) exp_bin[k] = (k < 16) ? 32'd1 : 32'd0;
`ifdef HIST_CDF_EN
    to_cdf(256, 64'hFFFF_FFFF);
`endif
    checks++; if (timeout) begin errors++; $display("FAIL basic_timeout: done_o not seen, want done_o"); end
    checks++; if (hs !== 256) begin errors++; $display("FAIL basic_words: got %0d, want 256", hs); end
    checks++; if (order_err !== 0) begin errors++; $display("FAIL basic_order: got %0d, want 0", order_err); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: got %0d, want 1", done_cnt); end
    checks++; if (last_cnt !== 1) begin errors++; $display("FAIL basic_last_count: got %0d, want 1", last_cnt); end
    checks++; if (last_idx !== 255) begin errors++; $display("FAIL basic_last_idx: got %0d, want 255", last_idx); end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (cap[k] !== exp_bin[k]) begin
        errors++; $display("FAIL basic_bin[%0d]: got %0d, want %0d", k, cap[k], exp_bin[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 16; k++) px[k] = 8'h7F;
    run_frame(0, 16, 1'b0, 1'b0);
    for (int k = 0; k < 256; k++) exp_bin[k] = (k == 127) ? 32'd16 : 32'd0;
`ifdef HIST_CDF_EN
    to_cdf(256, 64'hFFFF_FFFF);
`endif
    checks++; if (timeout) begin errors++; $display("FAIL b2b_timeout: done_o not seen, want done_o"); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done: got %0d, want 1", done_cnt); end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (cap[k] !== exp_bin[k]) begin
        errors++; $display("FAIL b2b_bin[%0d]: got %0d, want %0d", k, cap[k], exp_bin[k]);
      end
    end
  endtask

  task automatic test_bin_shift;
    px[0] = 8'h00; px[1] = 8'h0F; px[2] = 8'h10; px[3] = 8'hFF;
    run_frame(1, 4, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++)
      exp_bin[k] = (k == 0) ? 32'd2 : ((k == 1 || k == 15) ? 32'd1 : 32'd0);
`ifdef HIST_CDF_EN
    to_cdf(16, 64'hFFFF_FFFF);
`endif
    checks++; if (timeout) begin errors++; $display("FAIL shift_timeout: done_o not seen, want done_o"); end
    checks++; if (hs !== 16) begin errors++; $display("FAIL shift_words: got %0d, want 16", hs); end
    checks++; if (last_idx !== 15) begin errors++; $display("FAIL shift_last_idx: got %0d, want 15", last_idx); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== exp_bin[k]) begin
        errors++; $display("FAIL shift_bin[%0d]: got %0d, want %0d", k, cap[k], exp_bin[k]);
      end
    end
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 20; k++) px[k] = 8'd5;
    run_frame(2, 20, 1'b0, 1'b0);
    for (int k = 0; k < 256; k++) exp_bin[k] = (k == 5) ? 32'd15 : 32'd0;
`ifdef HIST_CDF_EN
    to_cdf(256, 64'd15);
`endif
    checks++; if (timeout) begin errors++; $display("FAIL sat_timeout: done_o not seen, want done_o"); end
    checks++; if (sat_c !== 1'b1) begin errors++; $display("FAIL sat_set: got %b, want 1", sat_c); end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (cap[k] !== exp_bin[k]) begin
        errors++; $display("FAIL sat_bin[%0d]: got %0d, want %0d", k, cap[k], exp_bin[k]);
      end
    end
    for (int k = 0; k < 20; k++) px[k] = k[7:0];
    run_frame(2, 20, 1'b0, 1'b0);
    for (int k = 0; k < 256; k++) exp_bin[k] = (k < 20) ? 32'd1 : 32'd0;
`ifdef HIST_CDF_EN
    to_cdf(256, 64'd15);
`endif
    checks++; if (sat_c !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b, want 0", sat_c); end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (cap[k] !== exp_bin[k]) begin
        errors++; $display("FAIL sat2_bin[%0d]: got %0d, want %0d", k, cap[k], exp_bin[k]);
      end
    end
  endtask

  task automatic test_readout_stall;
    for (int k = 0; k < 16; k++) px[k] = 8'((k % 4) * 50);
    run_frame(0, 16, 1'b1, 1'b0);
    for (int k = 0; k < 256; k++)
      exp_bin[k] = (k == 0 || k == 50 || k == 100 || k == 150) ? 32'd4 : 32'd0;
`ifdef HIST_CDF_EN
    to_cdf(256, 64'hFFFF_FFFF);
`endif
    checks++; if (timeout) begin errors++; $display("FAIL stall_timeout: done_o not seen, want done_o"); end
    checks++; if (hs !== 256) begin errors++; $display("FAIL stall_words: got %0d, want 256", hs); end
    checks++; if (order_err !== 0) begin errors++; $display("FAIL stall_order: got %0d, want 0", order_err); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold: got %0d, want 0", stall_viol); end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (cap[k] !== exp_bin[k]) begin
        errors++; $display("FAIL stall_bin[%0d]: got %0d, want %0d", k, cap[k], exp_bin[k]);
      end
    end
  endtask

  task automatic test_midframe_reset;
    int guard;
    sel = 0;
    @(posedge clk); #1;
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    guard = 0;
    while (!pr_a && guard < 1000) begin @(posedge clk); #1; guard++; end
    pv = 1'b1; pix = 8'd9;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0; pv = 1'b0;
    #2;
    checks++;
    if ({pr_a, rv_a, last_a, busy_a, done_a, sat_a, idx_a, cnt_a} !== '0) begin
      errors++; $display("FAIL midreset_async: got %h, want 0", {pr_a, rv_a, last_a, busy_a, done_a, sat_a, idx_a, cnt_a});
    end
    @(posedge clk); #1;
    checks++;
    if ({pr_a, busy_a} !== 2'b00) begin
      errors++; $display("FAIL midreset_held: got %b, want 00", {pr_a, busy_a});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({pr_a, busy_a} !== 2'b00) begin
      errors++; $display("FAIL midreset_idle: got %b, want 00", {pr_a, busy_a});
    end
    for (int k = 0; k < 16; k++) px[k] = 8'h20;
    run_frame(0, 16, 1'b0, 1'b0);
    for (int k = 0; k < 256; k++) exp_bin[k] = (k == 32) ? 32'd16 : 32'd0;
`ifdef HIST_CDF_EN
    to_cdf(256, 64'hFFFF_FFFF);
`endif
    checks++; if (timeout) begin errors++; $display("FAIL midreset_timeout: done_o not seen, want done_o"); end
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (cap[k] !== exp_bin[k]) begin
        errors++; $display("FAIL midreset_bin[%0d]: got %0d, want %0d", k, cap[k], exp_bin[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bin_shift();
    test_saturation();
    test_readout_stall();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
